// File: rtl/fir_chan_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fir_sched_pkg
//  Description : Shared constants, state encoding, coefficient table and the
//                output scaling helper for the multi-channel FIR scheduler.
//                Optional macro: FIR_CHAN_SCHED_SAT_EN (saturating rounding).
//  Revision    : 1.0  initial release
// ============================================================================
package fir_sched_pkg;

  localparam int TAPS_C = 11;
  localparam int COEF_W = 16;
  localparam int ACC_W  = 36;

  // Symmetric low-pass taps, Q1.15.
  localparam logic signed [COEF_W-1:0] COEF [TAPS_C] = '{
    16'hFF78, 16'hFE73, 16'hFFA9, 16'h0BBC, 16'h2092, 16'h2B86,
    16'h2092, 16'h0BBC, 16'hFFA9, 16'hFE73, 16'hFF78
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    RND  = 2'd2,
    OUT  = 2'd3
  } state_e;

  // Reduce the Q2.30-aligned accumulator to a Q1.15 sample (floor).
  function automatic logic [COEF_W-1:0] scale_acc(input logic signed [ACC_W-1:0] acc);
    logic [COEF_W-1:0] r;
`ifdef FIR_CHAN_SCHED_SAT_EN
    if (acc > 36'sh0_3FFF_FFFF) begin
      r = 16'h7FFF;
    end else if (acc < -36'sh0_4000_0000) begin
      r = 16'h8000;
    end else begin
      r = acc[30:15];
    end
`else
    r = acc[30:15];
`endif
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_chan_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : fir_chan_sched_if
//  Description : Sample request / result handshake bundle between the ADC
//                front end, the FIR scheduler and the downstream decimators.
//  Revision    : 1.0  initial release
// ============================================================================
interface fir_chan_sched_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [NCH-1:0]    in_valid;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_ready;
  logic              flush;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic              out_ready;
  logic              busy;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_data, out_ch, busy
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_data, out_ch, busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_chan_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin picker. Searches upward from ptr,
//                wrapping at NCH, and returns a one-hot grant and its index.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter #(
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  wire logic [NCH-1:0] req,
  input  wire logic [CHW-1:0] ptr,
  output logic      [NCH-1:0] grant,
  output logic      [CHW-1:0] grant_idx,
  output logic                grant_any
);

  localparam int CW1 = CHW + 1;

  logic [CHW:0] cand;

  // First requester at or after ptr wins; one extra bit absorbs the wrap.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < NCH; i++) begin
      cand = {1'b0, ptr} + CW1'(i);
      if (cand >= CW1'(NCH)) begin
        cand = cand - CW1'(NCH);
      end
      if (!grant_any && req[cand[CHW-1:0]]) begin
        grant_any                = 1'b1;
        grant_idx                = cand[CHW-1:0];
        grant[cand[CHW-1:0]]     = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fir_chan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fir_chan_sched
//  Description : Shares one serial 11-tap FIR MAC among NCH channels. Each
//                channel owns its delay line; requests are served round-robin
//                and every accepted sample yields one tagged output.
//                Optional macro: FIR_CHAN_SCHED_SAT_EN (saturate in RND).
//  Revision    : 1.0  initial release
// ============================================================================
module fir_chan_sched
  import fir_sched_pkg::*;
#(
  parameter int NCH  = 4,
  parameter int TAPS = 11,
  parameter int DW   = 16
) (
  input wire logic         clk,
  input wire logic         reset_p,
  fir_chan_sched_if.slave  bus
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int TW  = $clog2(TAPS);
  localparam int PW  = 2 * DW;

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [TW-1:0]           t_q, t_d;
  logic [CHW-1:0]          cur_ch_q, cur_ch_d;
  logic [CHW-1:0]          rr_ptr_q, rr_ptr_d;
  logic signed [DW-1:0]    h_q [NCH][TAPS];
  logic signed [DW-1:0]    h_d [NCH][TAPS];
  logic                    out_valid_q, out_valid_d;
  logic [DW-1:0]           out_data_q, out_data_d;
  logic [CHW-1:0]          out_ch_q, out_ch_d;

  logic [NCH-1:0]          grant_w;
  logic [CHW-1:0]          grant_idx_w;
  logic                    grant_any_w;
  logic [NCH-1:0]          in_ready_w;
  logic                    take_w;
  logic signed [DW-1:0]    coef_w;
  logic signed [DW-1:0]    tap_w;
  logic signed [PW-1:0]    prod_w;

  rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .req       (bus.in_valid),
    .ptr       (rr_ptr_q),
    .grant     (grant_w),
    .grant_idx (grant_idx_w),
    .grant_any (grant_any_w)
  );

  // Grants are only offered while idle and never during flush or reset.
  always_comb begin
    in_ready_w = '0;
    if (state_q == IDLE && !bus.flush && !reset_p && grant_any_w) begin
      in_ready_w = grant_w;
    end
    take_w = |(bus.in_valid & in_ready_w);
  end

  // One tap product per MAC cycle, taken from the channel being served.
  always_comb begin
    coef_w = COEF[t_q];
    tap_w  = h_q[cur_ch_q][t_q];
    prod_w = coef_w * tap_w;
  end

  // Next-state logic for the sequencer, delay lines and result registers.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    t_d         = t_q;
    cur_ch_d    = cur_ch_q;
    rr_ptr_d    = rr_ptr_q;
    h_d         = h_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    case (state_q)
      IDLE: begin
        if (take_w) begin
          for (int t = TAPS - 1; t > 0; t--) begin
            h_d[grant_idx_w][t] = h_q[grant_idx_w][t-1];
          end
          h_d[grant_idx_w][0] = bus.in_data[grant_idx_w*DW +: DW];
          acc_d    = '0;
          t_d      = '0;
          cur_ch_d = grant_idx_w;
          rr_ptr_d = (grant_idx_w == CHW'(NCH - 1)) ? '0 : grant_idx_w + CHW'(1);
          state_d  = MAC;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACC_W-PW){prod_w[PW-1]}}, prod_w};
        if (t_q == TW'(TAPS - 1)) begin
          t_d     = '0;
          state_d = RND;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      RND: begin
        out_data_d  = scale_acc(acc_q);
        out_ch_d    = cur_ch_q;
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Flush wins over everything, including a result waiting in OUT.
    if (bus.flush) begin
      state_d     = IDLE;
      acc_d       = '0;
      t_d         = '0;
      cur_ch_d    = '0;
      rr_ptr_d    = '0;
      out_valid_d = 1'b0;
      for (int g = 0; g < NCH; g++) begin
        for (int t = 0; t < TAPS; t++) begin
          h_d[g][t] = '0;
        end
      end
    end
  end

  // State register bank; reset clears everything including all histories.
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      t_q         <= '0;
      cur_ch_q    <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      for (int g = 0; g < NCH; g++) begin
        for (int t = 0; t < TAPS; t++) begin
          h_q[g][t] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      t_q         <= t_d;
      cur_ch_q    <= cur_ch_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      h_q         <= h_d;
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fir_chan_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fir_chan_sched
//  Description : Directed self-checking bench for fir_chan_sched (NCH = 4).
//                Honours FIR_CHAN_SCHED_SAT_EN for the overflow expectation.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fir_chan_sched;

  logic clk = 1'b0;
  logic reset_p = 1'b1;
  int   vec  = 0;
  int   errs = 0;
  int   cyc  = 0;

  logic [15:0] exp_imp [11] = '{16'hFFBC, 16'hFF39, 16'hFFD4, 16'h05DE, 16'h1049, 16'h15C3,
                                16'h1049, 16'h05DE, 16'hFFD4, 16'hFF39, 16'hFFBC};
  logic [15:0] sat_seq [11] = '{16'h8000, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF,
                                16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000};
  logic [3:0]  exp_rr  [5]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  fir_chan_sched_if #(.NCH(4), .DW(16)) bus ();

  fir_chan_sched #(.NCH(4), .TAPS(11), .DW(16)) dut (
    .clk     (clk),
    .reset_p (reset_p),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset();
    @(negedge clk);
    reset_p = 1'b1;
    bus.in_valid = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
  endtask

  // Offer one sample on channel ch, wait for its result, let it drain.
  task automatic send(input int ch, input logic [15:0] d,
                      output logic [15:0] od, output logic [1:0] och, output int lat);
    int n;
    @(negedge clk);
    bus.in_data[ch*16 +: 16] = d;
    bus.in_valid = 4'(1 << ch);
    bus.out_ready = 1'b1;
    #1;
    n = 0;
    while (bus.in_ready[ch] !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 40) begin
      vec++; errs++;
      $display("FAIL grant_timeout ch=%0d in_ready=%b required bit set", ch, bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = '0;
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); @(negedge clk); lat++;
    end
    od  = bus.out_data;
    och = bus.out_ch;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [15:0] od; logic [1:0] och; int lat; int n;
    bus.in_valid = 4'hF;
    bus.in_data = '0;
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk); #1;
    vec++; if (bus.in_ready !== 4'b0) begin errs++; $display("FAIL rst_in_ready got=%b want=0000", bus.in_ready); end
    vec++; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin errs++; $display("FAIL rst_flags got valid=%b busy=%b want 0 0", bus.out_valid, bus.busy); end
    vec++; if (bus.out_data !== 16'h0 || bus.out_ch !== 2'd0) begin errs++; $display("FAIL rst_outputs got data=%h ch=%0d want 0000 0", bus.out_data, bus.out_ch); end
    bus.in_valid = '0;
    reset_p = 1'b0;
    // start a channel-0 job and kill it mid-MAC
    @(negedge clk);
    bus.in_data[15:0] = 16'h7FFF;
    bus.in_valid = 4'b0001;
    #1; n = 0;
    while (bus.in_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk);
    bus.in_valid = '0;
    repeat (3) @(negedge clk);
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL mid_mac_busy got=%b want=1", bus.busy); end
    reset_p = 1'b1;
    bus.in_valid = 4'hF;
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL async_rst got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid); end
    vec++; if (bus.in_ready !== 4'b0) begin errs++; $display("FAIL async_rst_ready got=%b want=0000", bus.in_ready); end
    @(negedge clk);
    reset_p = 1'b0;
    bus.in_valid = '0;
    send(0, 16'h4000, od, och, lat);
    vec++; if (od !== 16'hFFBC) begin errs++; $display("FAIL post_rst_impulse got=%h want=ffbc", od); end
  endtask

  task automatic test_impulse();
    logic [15:0] od; logic [1:0] och; int lat;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send(0, (i == 0) ? 16'h4000 : 16'h0000, od, och, lat);
      vec++; if (od !== exp_imp[i]) begin errs++; $display("FAIL impulse[%0d] got=%h want=%h", i, od, exp_imp[i]); end
      vec++; if (och !== 2'd0) begin errs++; $display("FAIL impulse_ch[%0d] got=%0d want=0", i, och); end
      vec++; if (lat !== 12) begin errs++; $display("FAIL impulse_lat[%0d] got=%0d want=12", i, lat); end
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] od; logic [1:0] och; int lat; int n; int last;
    do_reset();
    bus.in_data = '0;
    bus.in_valid = 4'hF;
    last = 0;
    for (int k = 0; k < 5; k++) begin
      #1; n = 0;
      while (bus.in_ready === 4'b0 && n < 40) begin @(negedge clk); #1; n++; end
      vec++; if (bus.in_ready !== exp_rr[k]) begin errs++; $display("FAIL rr_grant[%0d] got=%b want=%b", k, bus.in_ready, exp_rr[k]); end
      if (k > 0) begin
        vec++; if ((cyc + 1 - last) !== 14) begin errs++; $display("FAIL rr_spacing[%0d] got=%0d want=14", k, cyc + 1 - last); end
      end
      last = cyc + 1;
      @(posedge clk); @(negedge clk);
    end
    bus.in_valid = '0;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin @(negedge clk); n++; end
    // interleave: channel 2 impulse, channel 3 DC full scale
    for (int i = 0; i < 11; i++) begin
      send(2, (i == 0) ? 16'h4000 : 16'h0000, od, och, lat);
      vec++; if (od !== exp_imp[i] || och !== 2'd2) begin errs++; $display("FAIL rr_ch2[%0d] got=%h/%0d want=%h/2", i, od, och, exp_imp[i]); end
      send(3, 16'h7FFF, od, och, lat);
    end
    vec++; if (od !== 16'h7F49 || och !== 2'd3) begin errs++; $display("FAIL rr_ch3_dc got=%h/%0d want=7f49/3", od, och); end
  endtask

  task automatic test_saturation();
    logic [15:0] od; logic [1:0] och; int lat; logic [15:0] want;
`ifdef FIR_CHAN_SCHED_SAT_EN
    want = 16'h7FFF;
`else
    want = 16'h88F8;
`endif
    do_reset();
    for (int i = 0; i < 11; i++) send(1, sat_seq[i], od, och, lat);
    vec++; if (od !== want) begin errs++; $display("FAIL sat_out got=%h want=%h", od, want); end
    vec++; if (och !== 2'd1) begin errs++; $display("FAIL sat_ch got=%0d want=1", och); end
  endtask

  task automatic test_back_pressure();
    int n;
    do_reset();
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_data[15:0] = 16'h4000;
    bus.in_valid = 4'b0001;
    #1; n = 0;
    while (bus.in_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk);
    bus.in_data[31:16] = 16'h1000;
    bus.in_valid = 4'b0010;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    for (int i = 0; i < 20; i++) begin
      #1;
      vec++; if ({bus.out_valid, bus.out_data, bus.out_ch} !== {1'b1, 16'hFFBC, 2'd0}) begin
        errs++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d want=1/ffbc/0", i, bus.out_valid, bus.out_data, bus.out_ch);
      end
      vec++; if (bus.in_ready !== 4'b0) begin errs++; $display("FAIL bp_ready[%0d] got=%b want=0000", i, bus.in_ready); end
      @(posedge clk); @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); @(negedge clk); #1;
    vec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 4'b0010) begin
      errs++; $display("FAIL bp_release got valid=%b in_ready=%b want 0 0010", bus.out_valid, bus.in_ready);
    end
    @(posedge clk); @(negedge clk);
    bus.in_valid = '0;
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL bp_next_accept got busy=%b want=1", bus.busy); end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin @(posedge clk); @(negedge clk); n++; end
    vec++; if (bus.out_data !== 16'hFFEF || bus.out_ch !== 2'd1) begin
      errs++; $display("FAIL bp_ch1 got=%h/%0d want=ffef/1", bus.out_data, bus.out_ch);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_flush();
    logic [15:0] od; logic [1:0] och; int lat; int n; int seen;
    do_reset();
    send(0, 16'h4000, od, och, lat);
    vec++; if (od !== 16'hFFBC) begin errs++; $display("FAIL flush_pre got=%h want=ffbc", od); end
    bus.in_data[15:0] = 16'h4000;
    bus.in_valid = 4'b0001;
    #1; n = 0;
    while (bus.in_ready[0] !== 1'b1 && n < 40) begin @(negedge clk); #1; n++; end
    @(posedge clk); @(negedge clk);
    bus.in_valid = '0;
    repeat (4) @(negedge clk);
    vec++; if (bus.busy !== 1'b1) begin errs++; $display("FAIL flush_in_mac got busy=%b want=1", bus.busy); end
    bus.flush = 1'b1;
    bus.in_valid = 4'b0001;
    #1;
    vec++; if (bus.in_ready !== 4'b0) begin errs++; $display("FAIL flush_ready_mac got=%b want=0000", bus.in_ready); end
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    bus.in_valid = '0;
    #1;
    vec++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errs++; $display("FAIL flush_abort got busy=%b valid=%b want 0 0", bus.busy, bus.out_valid); end
    seen = 0;
    for (int i = 0; i < 15; i++) begin @(negedge clk); if (bus.out_valid === 1'b1) seen++; end
    vec++; if (seen !== 0) begin errs++; $display("FAIL flush_no_result got=%0d valid cycles want=0", seen); end
    bus.flush = 1'b1;
    bus.in_valid = 4'b0011;
    #1;
    vec++; if (bus.in_ready !== 4'b0) begin errs++; $display("FAIL flush_ready_idle got=%b want=0000", bus.in_ready); end
    @(posedge clk); @(negedge clk);
    bus.flush = 1'b0;
    #1;
    vec++; if (bus.busy !== 1'b0) begin errs++; $display("FAIL flush_no_accept got busy=%b want=0", bus.busy); end
    vec++; if (bus.in_ready !== 4'b0001) begin errs++; $display("FAIL flush_rr_ptr got=%b want=0001", bus.in_ready); end
    bus.in_valid = '0;
    send(0, 16'h4000, od, och, lat);
    vec++; if (od !== 16'hFFBC) begin errs++; $display("FAIL flush_history got=%h want=ffbc", od); end
  endtask

  initial begin
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    test_reset();
    test_impulse();
    test_round_robin();
    test_saturation();
    test_back_pressure();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached vectors=%0d", vec);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
